// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_arb_pkg;

    localparam int WORD_W             = 32;
    localparam int DEF_MAX_DGRANT     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    // Command latched at grant time and held on the memory port until completion.
    typedef struct packed {
        logic  we;
        word_t addr;
        word_t wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the memory (slave).
// Latency: n/a (wires only).
// Backpressure: m_ready completes the transaction held by m_req.
interface mem_port_arbiter_if;
    import mips_arb_pkg::*;

    logic  m_req;
    logic  m_we;
    word_t m_addr;
    word_t m_wdata;
    word_t m_rdata;
    logic  m_ready;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ready
    );

endinterface

// File: rtl/mem_port_arbiter_grant_logic.sv
// Combinational grant selection with ack-cycle masking and starvation-count update.
// Latency: 0 cycles (pure combinational).
// Backpressure: grants only while idle; a port whose ack is high this cycle is masked.
module arb_grant_logic
    import mips_arb_pkg::*;
#(
    parameter int MAX_DGRANT = DEF_MAX_DGRANT,
    parameter int CNT_W      = $clog2(MAX_DGRANT + 1)
) (
    input  logic             idle,
    input  logic             if_req,
    input  logic             d_req,
    input  logic             if_ack,
    input  logic             d_ack,
    input  logic [CNT_W-1:0] dgrant_cnt,
    output logic             grant_if,
    output logic             grant_d,
    output logic [CNT_W-1:0] dgrant_cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DGRANT);

    logic if_live;
    logic d_live;
    logic under_limit;

    // Data wins unless fetch is waiting and data has used up its consecutive-grant budget.
    always_comb begin
        if_live        = if_req & ~if_ack;
        d_live         = d_req & ~d_ack;
        under_limit    = (dgrant_cnt < CNT_MAX);
        grant_d        = idle & d_live & (~if_live | under_limit);
        grant_if       = idle & if_live & ~grant_d;
        dgrant_cnt_nxt = dgrant_cnt;
        if (idle) begin
            if (grant_if || !if_live) begin
                dgrant_cnt_nxt = '0;
            end else if (grant_d && under_limit) begin
                dgrant_cnt_nxt = dgrant_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (read-only) and data (load/store); optional watchdog under ARB_TIMEOUT_EN.
// Latency: request to m_req 1 cycle; ack on the edge sampling m_ready=1; minimum round trip 2 cycles.
// Backpressure: one transaction at a time; requesters hold req until ack, memory stalls by holding m_ready low.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int MAX_DGRANT = DEF_MAX_DGRANT
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  if_req,
    input  word_t if_addr,
    output logic  if_ack,
    output word_t if_rdata,
    output logic  if_err,
    input  logic  d_req,
    input  logic  d_we,
    input  word_t d_addr,
    input  word_t d_wdata,
    output logic  d_ack,
    output word_t d_rdata,
    output logic  d_err,
    mem_port_arbiter_if.master mem
);

    localparam int CNT_W = $clog2(MAX_DGRANT + 1);

    arb_state_e       state_q, state_nxt;
    mem_cmd_t         cmd_q, cmd_nxt;
    logic             m_req_q, m_req_nxt;
    logic             if_ack_nxt, d_ack_nxt;
    word_t            if_rdata_nxt, d_rdata_nxt;
    logic [CNT_W-1:0] dgrant_cnt_q, dgrant_cnt_nxt;
    logic             grant_if, grant_d;

`ifdef ARB_TIMEOUT_EN
    localparam int               TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_nxt;
    logic              if_err_nxt, d_err_nxt;
`endif

    arb_grant_logic #(
        .MAX_DGRANT (MAX_DGRANT),
        .CNT_W      (CNT_W)
    ) u_grant (
        .idle           (state_q == IDLE),
        .if_req         (if_req),
        .d_req          (d_req),
        .if_ack         (if_ack),
        .d_ack          (d_ack),
        .dgrant_cnt     (dgrant_cnt_q),
        .grant_if       (grant_if),
        .grant_d        (grant_d),
        .dgrant_cnt_nxt (dgrant_cnt_nxt)
    );

    // Next state: latch the winner's command in IDLE, complete (or time out) in BUSY.
    always_comb begin
        state_nxt    = state_q;
        cmd_nxt      = cmd_q;
        m_req_nxt    = m_req_q;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
`ifdef ARB_TIMEOUT_EN
        if_err_nxt   = 1'b0;
        d_err_nxt    = 1'b0;
        tcnt_nxt     = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                tcnt_nxt = '0;
`endif
                if (grant_d) begin
                    state_nxt = BUSY_D;
                    m_req_nxt = 1'b1;
                    cmd_nxt   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                    m_req_nxt = 1'b1;
                    cmd_nxt   = '{we: 1'b0, addr: if_addr, wdata: '0};
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem.m_ready) begin
                    state_nxt  = IDLE;
                    m_req_nxt  = 1'b0;
                    cmd_nxt.we = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem.m_rdata;
                    end else begin
                        d_ack_nxt = 1'b1;
                        if (!cmd_q.we) begin
                            d_rdata_nxt = mem.m_rdata;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TCNT_LAST) begin
                    // Give up: ack with error, leave the port's read data alone.
                    state_nxt  = IDLE;
                    m_req_nxt  = 1'b0;
                    cmd_nxt.we = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_ack_nxt = 1'b1;
                        if_err_nxt = 1'b1;
                    end else begin
                        d_ack_nxt = 1'b1;
                        d_err_nxt = 1'b1;
                    end
                end else begin
                    tcnt_nxt = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                m_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            m_req_q      <= 1'b0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            dgrant_cnt_q <= '0;
        end else begin
            state_q      <= state_nxt;
            cmd_q        <= cmd_nxt;
            m_req_q      <= m_req_nxt;
            if_ack       <= if_ack_nxt;
            d_ack        <= d_ack_nxt;
            if_rdata     <= if_rdata_nxt;
            d_rdata      <= d_rdata_nxt;
            dgrant_cnt_q <= dgrant_cnt_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            if_err <= 1'b0;
            d_err  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_nxt;
            if_err <= if_err_nxt;
            d_err  <= d_err_nxt;
        end
    end
`else
    assign if_err = 1'b0;
    assign d_err  = 1'b0;
`endif

    assign mem.m_req   = m_req_q;
    assign mem.m_we    = cmd_q.we;
    assign mem.m_addr  = cmd_q.addr;
    assign mem.m_wdata = cmd_q.wdata;

endmodule
